// File: rtl/convertidor_escala_pkg.sv
// Shared types and constants for the ratio scaler: FSM states, rounding modes,
// and the width of the rounded product that feeds the divider.
package convertidor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  // Product width plus one bit of headroom for the rounding addend.
  function automatic int calc_p_w(input int in_w, input int num_w);
    return in_w + num_w + 1;
  endfunction

endpackage

// File: rtl/convertidor_escala_if.sv
// Request/result handshake bundle of the ratio scaler; master is the producer
// and consumer side, slave is the scaler itself.
interface convertidor_escala_if #(
  parameter int IN_W  = 8,
  parameter int NUM_W = 4,
  parameter int DEN_W = 4,
  parameter int OUT_W = 10,
  parameter int TAG_W = 2
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  din;
  logic [NUM_W-1:0] num;
  logic [DEN_W-1:0] den;
  logic             round_en;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dout;
  logic [TAG_W-1:0] tag_out;
  logic             sat;
  logic             div0;

  modport master (
    output in_valid, din, num, den, round_en, tag_in, out_ready,
    input  in_ready, out_valid, dout, tag_out, sat, div0
  );

  modport slave (
    input  in_valid, din, num, den, round_en, tag_in, out_ready,
    output in_ready, out_valid, dout, tag_out, sat, div0
  );

endinterface

// File: rtl/convertidor_div_paso.sv
// One restoring-division step: shift the next dividend bit into the remainder
// and subtract the divisor when it fits.
module convertidor_div_paso #(
  parameter int DEN_W = 4
) (
  input  logic [DEN_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DEN_W-1:0] divisor,
  output logic [DEN_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DEN_W:0] trial;

  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, divisor});
    rem_out = q_bit ? DEN_W'(trial - {1'b0, divisor}) : trial[DEN_W-1:0];
  end

endmodule

// File: rtl/convertidor_escala.sv
// Sequential ratio scaler dout = din*num/den: one multiply cycle, then a
// bit-serial restoring divide, with saturation, rounding and a div-by-zero flag.
module convertidor_escala
  import convertidor_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int NUM_W = 4,
  parameter int DEN_W = 4,
  parameter int OUT_W = 10,
  parameter int TAG_W = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  convertidor_escala_if.slave bus
);

  localparam int P_W     = calc_p_w(IN_W, NUM_W);
  localparam int CNT_W   = $clog2(P_W);
  localparam int MAX_OUT = (1 << OUT_W) - 1;

  state_e           state_reg, state_next;
  logic [IN_W-1:0]  din_reg;
  logic [NUM_W-1:0] num_reg;
  logic [DEN_W-1:0] den_reg;
  logic             rnd_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [P_W-1:0]   dividend_reg;
  logic [DEN_W-1:0] rem_reg;
  logic [P_W-2:0]   quo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [OUT_W-1:0] dout_reg;
  logic [TAG_W-1:0] tag_out_reg;
  logic             sat_reg;
  logic             div0_reg;

  logic [DEN_W-1:0] step_rem;
  logic             step_q;
  logic [P_W-1:0]   q_final;
  logic [P_W-1:0]   p_mul;
  logic             last_step;

  convertidor_div_paso #(.DEN_W(DEN_W)) u_paso (
    .rem_in  (rem_reg),
    .bit_in  (dividend_reg[P_W-1]),
    .divisor (den_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_final   = {quo_reg, step_q};
  assign last_step = (cnt_reg == CNT_W'(P_W - 1));
  assign p_mul     = P_W'(din_reg) * P_W'(num_reg)
                   + ((rnd_reg == RND_HALF_UP) ? P_W'(den_reg >> 1) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = MUL;
      MUL:     state_next = (den_reg == '0) ? DONE : DIV;
      DIV:     if (last_step) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_reg      <= '0;
      num_reg      <= '0;
      den_reg      <= '0;
      rnd_reg      <= 1'b0;
      tag_reg      <= '0;
      dividend_reg <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      cnt_reg      <= '0;
      dout_reg     <= '0;
      tag_out_reg  <= '0;
      sat_reg      <= 1'b0;
      div0_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            din_reg <= bus.din;
            num_reg <= bus.num;
            den_reg <= bus.den;
            rnd_reg <= bus.round_en;
            tag_reg <= bus.tag_in;
          end
        end
        MUL: begin
          if (den_reg == '0) begin
            dout_reg    <= '1;
            sat_reg     <= 1'b0;
            div0_reg    <= 1'b1;
            tag_out_reg <= tag_reg;
          end else begin
            dividend_reg <= p_mul;
            rem_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
          end
        end
        DIV: begin
          dividend_reg <= {dividend_reg[P_W-2:0], 1'b0};
          rem_reg      <= step_rem;
          quo_reg      <= q_final[P_W-2:0];
          cnt_reg      <= cnt_reg + CNT_W'(1);
          // Results are committed only on the final step, so an aborted divide never shows.
          if (last_step) begin
            div0_reg    <= 1'b0;
            tag_out_reg <= tag_reg;
            if (q_final > P_W'(MAX_OUT)) begin
              dout_reg <= '1;
              sat_reg  <= 1'b1;
            end else begin
              dout_reg <= q_final[OUT_W-1:0];
              sat_reg  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.dout      = dout_reg;
  assign bus.tag_out   = tag_out_reg;
  assign bus.sat       = sat_reg;
  assign bus.div0      = div0_reg;

endmodule
